// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 instruction fetch/split.
// Splits the ten bytes at PC into icode/ifun/rA/rB/valC and computes the
// sequential next PC. It also flags illegal encodings and fetches that run
// past the end of instruction memory. Fully combinational, and rst_n
// substitutes a nop bubble on every output.
module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic [0:79] instr,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        memory_error,
    output logic        instr_valid
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // clk is kept only for pipeline alignment; nothing here is clocked.
    logic unused_clk;
    assign unused_clk = clk;

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic [7:0]  ib [10];
    logic [3:0]  ifun_max;
    logic        dec_ok;
    logic [3:0]  ilen;
    logic        has_reg;
    logic        const_at1;
    logic        const_at2;
    logic [63:0] dec_valc;
    logic [63:0] dec_valp;
    logic [64:0] end_addr;
    logic        dec_merr;

    assign raw_icode = instr[0:3];
    assign raw_ifun  = instr[4:7];

    // Slice the instruction stream into bytes; byte k is at address PC+k.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            ib[k] = instr[8*k +: 8];
        end
    end

    // Classify the opcode: legality, length, and where the fields live.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned (which would infer a latch).
        ifun_max  = 4'h0;
        dec_ok    = 1'b1;
        ilen      = 4'd1;
        has_reg   = 1'b0;
        const_at1 = 1'b0;
        const_at2 = 1'b0;
        case (raw_icode)
            I_HALT, I_NOP, I_RET: ;
            I_CMOVXX: begin
                ilen     = 4'd2;
                has_reg  = 1'b1;
                ifun_max = 4'h6;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                ilen      = 4'd10;
                has_reg   = 1'b1;
                const_at2 = 1'b1;
            end
            I_OPQ: begin
                ilen     = 4'd2;
                has_reg  = 1'b1;
                ifun_max = 4'h3;
            end
            I_JXX: begin
                ilen      = 4'd9;
                const_at1 = 1'b1;
                ifun_max  = 4'h6;
            end
            I_CALL: begin
                ilen      = 4'd9;
                const_at1 = 1'b1;
            end
            I_PUSHQ, I_POPQ: begin
                ilen    = 4'd2;
                has_reg = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
        if (raw_ifun > ifun_max) begin
            dec_ok = 1'b0;
        end
        // An illegal encoding is consumed as a single byte with no fields.
        if (!dec_ok) begin
            ilen      = 4'd1;
            has_reg   = 1'b0;
            const_at1 = 1'b0;
            const_at2 = 1'b0;
        end
    end

    // Assemble the little-endian constant word from whichever byte it starts at.
    always_comb begin
        dec_valc = 64'h0;
        if (const_at2) begin
            dec_valc = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
        end else if (const_at1) begin
            dec_valc = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
        end
    end

    // Next PC wraps at 2^64; the range check uses one extra bit so it cannot wrap.
    always_comb begin
        dec_valp = PC + {60'h0, ilen};
        end_addr = {1'b0, PC} + {61'h0, ilen};
        dec_merr = end_addr > 65'(IMEM_BYTES);
    end

    // Drive the outputs, substituting the nop bubble while reset is asserted.
    always_comb begin
        if (!rst_n) begin
            icode        = I_NOP;
            ifun         = 4'h0;
            rA           = 4'hF;
            rB           = 4'hF;
            valC         = 64'h0;
            valP         = 64'h0;
            memory_error = 1'b0;
            instr_valid  = 1'b1;
        end else begin
            icode        = raw_icode;
            ifun         = raw_ifun;
            rA           = has_reg ? instr[8:11]  : 4'hF;
            rB           = has_reg ? instr[12:15] : 4'hF;
            valC         = dec_valc;
            valP         = dec_valp;
            memory_error = dec_merr;
            instr_valid  = dec_ok;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors, reset sequences and randomized decode
// checked against an opcode-table reference model.
module tb_fetch_stage;

    localparam int unsigned IMEM = 256;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        merr;
        logic        valid;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [0:79] instr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        clk_run = 1'b1;
    logic        rst_n;
    logic [63:0] pc;
    logic [0:79] instr;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        merr, valid;

    int checks = 0;
    int failures = 0;

    always #5 if (clk_run) clk = ~clk;

    fetch_stage #(.IMEM_BYTES(IMEM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC           (pc),
        .instr        (instr),
        .icode        (icode),
        .ifun         (ifun),
        .rA           (ra),
        .rB           (rb),
        .valC         (valc),
        .valP         (valp),
        .memory_error (merr),
        .instr_valid  (valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".icode"}, 64'(icode), 64'(e.icode));
        check({tag, ".ifun"},  64'(ifun),  64'(e.ifun));
        check({tag, ".rA"},    64'(ra),    64'(e.ra));
        check({tag, ".rB"},    64'(rb),    64'(e.rb));
        check({tag, ".valC"},  valc,       e.valc);
        check({tag, ".valP"},  valp,       e.valp);
        check({tag, ".memory_error"}, 64'(merr),  64'(e.merr));
        check({tag, ".instr_valid"},  64'(valid), 64'(e.valid));
    endtask

    function automatic exp_t mk_exp(logic [3:0] ic, logic [3:0] fn, logic [3:0] a, logic [3:0] b,
                                    logic [63:0] vc, logic [63:0] vp, logic me, logic va);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b;
        e.valc = vc; e.valp = vp; e.merr = me; e.valid = va;
        return e;
    endfunction

    function automatic vec_t mk(string n, logic [63:0] p, logic [0:79] ins, exp_t e);
        vec_t v;
        v.name = n; v.pc = p; v.instr = ins; v.e = e;
        return v;
    endfunction

    // Reference model: table of lengths and ifun limits from the ISA listing.
    function automatic exp_t model(input logic [63:0] p, input logic [0:79] ins);
        int   len_tab [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
        int   fun_max [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
        exp_t e;
        int   len;
        bit   ok;
        e.icode = ins[0:3];
        e.ifun  = ins[4:7];
        ok = 1'b0;
        if (int'(e.icode) < 12) begin
            ok = int'(e.ifun) <= fun_max[e.icode];
        end
        len = ok ? len_tab[e.icode] : 1;
        e.ra = 4'hF;
        e.rb = 4'hF;
        if (len == 2 || len == 10) begin
            e.ra = ins[8:11];
            e.rb = ins[12:15];
        end
        e.valc = 64'h0;
        if (len >= 9) begin
            for (int n = 0; n < 8; n++) begin
                e.valc = e.valc | (64'(ins[8*(len-8+n) +: 8]) << (8*n));
            end
        end
        e.valp  = p + 64'(len);
        e.merr  = (65'(p) + 65'(len)) > 65'(IMEM);
        e.valid = ok;
        return e;
    endfunction

    vec_t vecs[$];
    exp_t bubble;

    initial begin
        bubble = mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);

        vecs.push_back(mk("mrmovq", 64'd34, 80'h5021_0000_0102_0304_0506,
            mk_exp(4'h5, 4'h0, 4'h2, 4'h1, 64'h0605040302010000, 64'd44, 1'b0, 1'b1)));
        vecs.push_back(mk("jxx", 64'd100, 80'h7320_0100_0000_0000_0000,
            mk_exp(4'h7, 4'h3, 4'hF, 4'hF, 64'h120, 64'd109, 1'b0, 1'b1)));
        vecs.push_back(mk("halt", 64'd0, 80'h0,
            mk_exp(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b0, 1'b1)));
        vecs.push_back(mk("nop", 64'd7, 80'h1000_0000_0000_0000_0000,
            mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd8, 1'b0, 1'b1)));
        vecs.push_back(mk("opq", 64'd20, 80'h6123_0000_0000_0000_0000,
            mk_exp(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'd22, 1'b0, 1'b1)));
        vecs.push_back(mk("bad_c0", 64'd5, 80'hC012_3456_789A_BCDE_F012,
            mk_exp(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd6, 1'b0, 1'b0)));
        vecs.push_back(mk("bad_27", 64'd5, 80'h2745_0000_0000_0000_0000,
            mk_exp(4'h2, 4'h7, 4'hF, 4'hF, 64'h0, 64'd6, 1'b0, 1'b0)));
        vecs.push_back(mk("bad_64", 64'd9, 80'h6412_0000_0000_0000_0000,
            mk_exp(4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'd10, 1'b0, 1'b0)));
        vecs.push_back(mk("cmov_f6", 64'd3, 80'h2612_0000_0000_0000_0000,
            mk_exp(4'h2, 4'h6, 4'h1, 4'h2, 64'h0, 64'd5, 1'b0, 1'b1)));
        vecs.push_back(mk("call", 64'd16, 80'h8011_2233_4455_6677_8800,
            mk_exp(4'h8, 4'h0, 4'hF, 4'hF, 64'h8877665544332211, 64'd25, 1'b0, 1'b1)));
        vecs.push_back(mk("pushq", 64'h40, 80'hA04F_0000_0000_0000_0000,
            mk_exp(4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'h42, 1'b0, 1'b1)));
        vecs.push_back(mk("irmovq_250", 64'd250, 80'h30F3_0807_0605_0403_0201,
            mk_exp(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'd260, 1'b1, 1'b1)));
        vecs.push_back(mk("irmovq_246", 64'd246, 80'h30F3_0807_0605_0403_0201,
            mk_exp(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'd256, 1'b0, 1'b1)));
        vecs.push_back(mk("nop_255", 64'd255, 80'h1000_0000_0000_0000_0000,
            mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd256, 1'b0, 1'b1)));
        vecs.push_back(mk("nop_top", 64'hFFFF_FFFF_FFFF_FFFF, 80'h1000_0000_0000_0000_0000,
            mk_exp(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b1)));

        // Reset from time zero with a real instruction on the inputs.
        rst_n = 1'b0;
        pc    = vecs[0].pc;
        instr = vecs[0].instr;
        #1 check_outputs("reset", bubble);
        rst_n = 1'b1;
        #1 check_outputs("reset_release", vecs[0].e);

        // Directed table.
        foreach (vecs[i]) begin
            pc    = vecs[i].pc;
            instr = vecs[i].instr;
            #1 check_outputs(vecs[i].name, vecs[i].e);
        end

        // Mid-cycle asynchronous reset while mrmovq is presented.
        @(posedge clk);
        #2;
        pc    = vecs[0].pc;
        instr = vecs[0].instr;
        #1 check_outputs("pre_reset", vecs[0].e);
        rst_n = 1'b0;
        #1 check_outputs("async_reset", bubble);
        pc    = 64'd250;
        instr = vecs[11].instr;
        #1 check_outputs("reset_input_change", bubble);
        pc    = vecs[0].pc;
        instr = vecs[0].instr;
        rst_n = 1'b1;
        #1 check_outputs("async_release", vecs[0].e);

        // Stop the clock: decode must keep tracking inputs with no edges at all.
        clk_run = 1'b0;
        rst_n = 1'b0;
        #3 check_outputs("stopped_clk_reset", bubble);
        rst_n = 1'b1;
        #3 check_outputs("stopped_clk_release", vecs[0].e);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            logic [3:0] fn;
            ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0:       fn = 4'($urandom_range(0, 15));
                1:       fn = 4'($urandom_range(0, 6));
                default: fn = 4'h0;
            endcase
            case ($urandom_range(0, 3))
                0:       pc = 64'($urandom_range(0, 255));
                1:       pc = 64'($urandom_range(240, 260));
                2:       pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: pc = {$urandom, $urandom};
            endcase
            instr = {ic, fn, 8'($urandom), 32'($urandom), 32'($urandom)};
            #1 check_outputs($sformatf("rand%0d", n), model(pc, instr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
